// File: rtl/pce_cd_pkg.sv
// Shared definitions for the PCE CD-ROM SCSI target: phase codes, CDC_STAT
// signal masks, sequencer state encoding and small decode helpers.
package pce_cd_pkg;

    localparam logic [7:0] PH_BUS_FREE   = 8'h00;
    localparam logic [7:0] PH_COMMAND    = 8'h01;
    localparam logic [7:0] PH_DATA_IN    = 8'h02;
    localparam logic [7:0] PH_STATUS     = 8'h08;
    localparam logic [7:0] PH_MESSAGE_IN = 8'h10;

    localparam logic [7:0] SIG_BSY = 8'h80;
    localparam logic [7:0] SIG_REQ = 8'h40;
    localparam logic [7:0] SIG_MSG = 8'h20;
    localparam logic [7:0] SIG_CD  = 8'h10;
    localparam logic [7:0] SIG_IO  = 8'h08;

    localparam logic [7:0] MSG_COMMAND_COMPLETE = 8'h00;

    typedef enum logic [2:0] {
        ST_BUS_FREE,
        ST_COMMAND,
        ST_EXEC,
        ST_DATA_IN,
        ST_STATUS,
        ST_MESSAGE_IN
    } state_t;

    // Group 0 opcodes (top three bits zero) are 6-byte CDBs, the rest 10-byte.
    function automatic logic [3:0] cmd_len_of(input logic [2:0] group);
        return (group == 3'd0) ? 4'd6 : 4'd10;
    endfunction

    function automatic logic [7:0] phase_of(input state_t st);
        case (st)
            ST_COMMAND, ST_EXEC: return PH_COMMAND;
            ST_DATA_IN:          return PH_DATA_IN;
            ST_STATUS:           return PH_STATUS;
            ST_MESSAGE_IN:       return PH_MESSAGE_IN;
            default:             return PH_BUS_FREE;
        endcase
    endfunction

    // Bus signal lines driven in each state, REQ excluded.
    function automatic logic [7:0] signals_of(input state_t st);
        case (st)
            ST_COMMAND, ST_EXEC: return SIG_BSY | SIG_CD;
            ST_DATA_IN:          return SIG_BSY | SIG_IO;
            ST_STATUS:           return SIG_BSY | SIG_CD | SIG_IO;
            ST_MESSAGE_IN:       return SIG_BSY | SIG_MSG | SIG_CD | SIG_IO;
            default:             return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/scsi_req_ack_hs.sv
// Single-byte REQ/ACK full interlock: REQ rises on start, the byte moves when
// REQ and ACK are both high, and REQ may not rise again until ACK is seen low.
module scsi_req_ack_hs (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic xfer,
    output logic ready
);

    logic req_q;
    logic wait_ack_low;

    assign req   = req_q;
    assign xfer  = req_q & ack;
    // A new byte may be offered once ACK from the previous one is low.
    assign ready = !req_q && (!wait_ack_low || !ack);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            req_q        <= 1'b0;
            wait_ack_low <= 1'b0;
        end else if (xfer) begin
            req_q        <= 1'b0;
            wait_ack_low <= 1'b1;
        end else if (start && ready) begin
            req_q        <= 1'b1;
            wait_ack_low <= 1'b0;
        end else if (wait_ack_low && !ack) begin
            wait_ack_low <= 1'b0;
        end
    end

endmodule

// File: rtl/scsi_phase_sequencer.sv
// Target-side SCSI phase sequencer for the PCE CD-ROM interface.
// Define SCSI_PHASE_TIMEOUT_EN to add the REQ-without-ACK watchdog abort.
module scsi_phase_sequencer
    import pce_cd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_i,
    input  logic        ack_i,
    input  logic [7:0]  host_data_i,
    output logic [79:0] cmd_bytes_o,
    output logic [3:0]  cmd_len_o,
    output logic        cmd_valid_o,
    input  logic        dat_valid_i,
    input  logic [7:0]  dat_i,
    output logic        dat_ready_o,
    input  logic        status_valid_i,
    input  logic [7:0]  status_i,
    output logic [7:0]  bus_data_o,
    output logic [7:0]  cd_status_o,
    output logic [7:0]  phase_o,
    output logic        timeout_o
);

    state_t      state, state_nxt;
    logic [3:0]  byte_cnt;
    logic [79:0] cmd_bytes;
    logic [3:0]  cmd_len;
    logic        cmd_valid;
    logic        msg_sent;
    logic        timeout;
    logic [7:0]  bus_data;

    logic req, xfer, hs_ready, hs_start, abort;
    logic take_data, take_status, cmd_done, last_byte;

    // Byte 0 is never the last one, so a stale opcode at count 0 is harmless.
    assign last_byte = (byte_cnt == cmd_len_of(cmd_bytes[7:5]) - 4'd1);

    scsi_req_ack_hs u_hs (
        .clk   (clk),
        .reset (reset),
        .clear (abort),
        .start (hs_start),
        .ack   (ack_i),
        .req   (req),
        .xfer  (xfer),
        .ready (hs_ready)
    );

`ifdef SCSI_PHASE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    assign abort = req && !ack_i && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset || !req || ack_i || abort) tmo_cnt <= '0;
        else                                 tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        hs_start    = 1'b0;
        take_data   = 1'b0;
        take_status = 1'b0;
        cmd_done    = 1'b0;
        case (state)
            ST_BUS_FREE: begin
                if (sel_i) begin
                    state_nxt = ST_COMMAND;
                    hs_start  = 1'b1;
                end
            end
            ST_COMMAND: begin
                if (xfer && last_byte) begin
                    cmd_done  = 1'b1;
                    state_nxt = ST_EXEC;
                end else begin
                    hs_start = 1'b1;
                end
            end
            // Data has priority over status whenever both are offered.
            ST_EXEC, ST_DATA_IN: begin
                if (hs_ready) begin
                    if (dat_valid_i) begin
                        take_data = 1'b1;
                        hs_start  = 1'b1;
                        state_nxt = ST_DATA_IN;
                    end else if (status_valid_i) begin
                        take_status = 1'b1;
                        hs_start    = 1'b1;
                        state_nxt   = ST_STATUS;
                    end
                end
            end
            ST_STATUS: begin
                if (xfer) state_nxt = ST_MESSAGE_IN;
            end
            ST_MESSAGE_IN: begin
                if (msg_sent && !ack_i) state_nxt = ST_BUS_FREE;
                else if (!msg_sent)     hs_start  = 1'b1;
            end
            default: state_nxt = ST_BUS_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_BUS_FREE;
            byte_cnt  <= '0;
            cmd_bytes <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            msg_sent  <= 1'b0;
            timeout   <= 1'b0;
            bus_data  <= '0;
        end else if (abort) begin
            // Watchdog abort looks like reset but keeps the last command.
            state     <= ST_BUS_FREE;
            byte_cnt  <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            msg_sent  <= 1'b0;
            timeout   <= 1'b1;
            bus_data  <= '0;
        end else begin
            state     <= state_nxt;
            cmd_valid <= cmd_done;
            timeout   <= 1'b0;
            if (state == ST_BUS_FREE && sel_i) begin
                byte_cnt <= '0;
                cmd_len  <= '0;
            end
            if (state == ST_COMMAND && xfer) begin
                cmd_bytes[{byte_cnt, 3'b000} +: 8] <= host_data_i;
                byte_cnt <= byte_cnt + 4'd1;
            end
            if (cmd_done) cmd_len <= cmd_len_of(cmd_bytes[7:5]);
            if (take_data)                      bus_data <= dat_i;
            else if (take_status)               bus_data <= status_i;
            else if (state == ST_STATUS && xfer) bus_data <= MSG_COMMAND_COMPLETE;
            if (state == ST_STATUS)                   msg_sent <= 1'b0;
            else if (state == ST_MESSAGE_IN && xfer)  msg_sent <= 1'b1;
        end
    end

    assign cmd_bytes_o = cmd_bytes;
    assign cmd_len_o   = cmd_len;
    assign cmd_valid_o = cmd_valid;
    assign dat_ready_o = take_data & ~reset;
    assign bus_data_o  = bus_data;
    assign cd_status_o = signals_of(state) | (req ? SIG_REQ : 8'h00);
    assign phase_o     = phase_of(state);
    assign timeout_o   = timeout;

endmodule

// File: tb/tb_scsi_phase_sequencer.sv
// Bench for scsi_phase_sequencer: cycle table for a full 6-byte command
// transaction, then directed sequences (10-byte CDB, held ACK, watchdog, reset).
module tb_scsi_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel_i, ack_i, dat_valid_i, status_valid_i;
    logic [7:0]  host_data_i, dat_i, status_i;
    logic [79:0] cmd_bytes_o;
    logic [3:0]  cmd_len_o;
    logic        cmd_valid_o, dat_ready_o, timeout_o;
    logic [7:0]  bus_data_o, cd_status_o, phase_o;

    int tests = 0;
    int fails = 0;
    int cv_cnt = 0, dr_cnt = 0, to_cnt = 0;
    int cv0, dr0, to0;

    scsi_phase_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .sel_i          (sel_i),
        .ack_i          (ack_i),
        .host_data_i    (host_data_i),
        .cmd_bytes_o    (cmd_bytes_o),
        .cmd_len_o      (cmd_len_o),
        .cmd_valid_o    (cmd_valid_o),
        .dat_valid_i    (dat_valid_i),
        .dat_i          (dat_i),
        .dat_ready_o    (dat_ready_o),
        .status_valid_i (status_valid_i),
        .status_i       (status_i),
        .bus_data_o     (bus_data_o),
        .cd_status_o    (cd_status_o),
        .phase_o        (phase_o),
        .timeout_o      (timeout_o)
    );

    always @(negedge clk) begin
        if (cmd_valid_o) cv_cnt <= cv_cnt + 1;
        if (dat_ready_o) dr_cnt <= dr_cnt + 1;
        if (timeout_o)   to_cnt <= to_cnt + 1;
    end

    typedef struct {
        logic       rst, sel, ack;
        logic [7:0] hd;
        logic       dv;
        logic [7:0] dat;
        logic       sv;
        logic [7:0] st;
        logic [7:0] e_cd, e_ph, e_bd;
        logic       e_cv, e_dr;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t v(input logic rst, input logic sel, input logic ack,
                               input logic [7:0] hd, input logic dv, input logic [7:0] dat,
                               input logic sv, input logic [7:0] st,
                               input logic [7:0] cd, input logic [7:0] ph, input logic [7:0] bd,
                               input logic cv, input logic dr);
        vec_t r;
        r.rst = rst; r.sel = sel; r.ack = ack; r.hd = hd; r.dv = dv; r.dat = dat;
        r.sv = sv; r.st = st; r.e_cd = cd; r.e_ph = ph; r.e_bd = bd; r.e_cv = cv; r.e_dr = dr;
        return r;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!cd_status_o[6] && n < 20) begin
            step();
            n++;
        end
        check(name, 80'(cd_status_o[6]), 80'(1'b1));
    endtask

    task automatic send_cmd(input logic [7:0] b [10], input int len);
        for (int i = 0; i < len; i++) begin
            wait_req("cmd_req_up");
            host_data_i = b[i];
            ack_i = 1'b1;
            step();
            ack_i = 1'b0;
            step();
            if (len == 10 && i == 5) begin
                check("cmd10_no_pulse_after_6", 80'(cv_cnt - cv0), 80'(0));
                check("cmd10_len_not_yet", 80'(cmd_len_o == 4'd10), 80'(1'b0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] cmd10 [10];
        logic [7:0] cmd6 [10];
        logic ok;
        cmd10 = '{8'h28, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        cmd6  = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        //              rst sel ack hd    dv dat    sv st     cd     ph     bd    cv dr
        tbl[0]  = v(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        tbl[1]  = v(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
        tbl[2]  = v(0, 0, 1, 8'h08, 0, 8'h00, 0, 8'h00, 8'hD0, 8'h01, 8'h00, 0, 0);
        tbl[3]  = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 0);
        tbl[4]  = v(0, 0, 1, 8'h01, 0, 8'h00, 0, 8'h00, 8'hD0, 8'h01, 8'h00, 0, 0);
        tbl[5]  = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 0);
        tbl[6]  = v(0, 0, 1, 8'h02, 0, 8'h00, 0, 8'h00, 8'hD0, 8'h01, 8'h00, 0, 0);
        tbl[7]  = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 0);
        tbl[8]  = v(0, 0, 1, 8'h03, 0, 8'h00, 0, 8'h00, 8'hD0, 8'h01, 8'h00, 0, 0);
        tbl[9]  = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 0);
        tbl[10] = v(0, 0, 1, 8'h04, 0, 8'h00, 0, 8'h00, 8'hD0, 8'h01, 8'h00, 0, 0);
        tbl[11] = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 0);
        tbl[12] = v(0, 0, 1, 8'h05, 0, 8'h00, 0, 8'h00, 8'hD0, 8'h01, 8'h00, 0, 0);
        tbl[13] = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 1, 0);
        tbl[14] = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 0);
        tbl[15] = v(0, 0, 0, 8'h00, 1, 8'hA1, 0, 8'h00, 8'h90, 8'h01, 8'h00, 0, 1);
        tbl[16] = v(0, 1, 1, 8'h00, 1, 8'hA2, 0, 8'h00, 8'hC8, 8'h02, 8'hA1, 0, 0);
        tbl[17] = v(0, 1, 0, 8'h00, 1, 8'hA2, 0, 8'h00, 8'h88, 8'h02, 8'hA1, 0, 1);
        tbl[18] = v(0, 1, 1, 8'h00, 1, 8'hA3, 0, 8'h00, 8'hC8, 8'h02, 8'hA2, 0, 0);
        tbl[19] = v(0, 0, 0, 8'h00, 1, 8'hA3, 0, 8'h00, 8'h88, 8'h02, 8'hA2, 0, 1);
        tbl[20] = v(0, 0, 1, 8'h00, 0, 8'h00, 1, 8'h00, 8'hC8, 8'h02, 8'hA3, 0, 0);
        tbl[21] = v(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h88, 8'h02, 8'hA3, 0, 0);
        tbl[22] = v(0, 0, 1, 8'h00, 0, 8'h00, 1, 8'h00, 8'hD8, 8'h08, 8'h00, 0, 0);
        tbl[23] = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hB8, 8'h10, 8'h00, 0, 0);
        tbl[24] = v(0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h00, 8'hF8, 8'h10, 8'h00, 0, 0);
        tbl[25] = v(0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h00, 8'hB8, 8'h10, 8'h00, 0, 0);
        tbl[26] = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hB8, 8'h10, 8'h00, 0, 0);
        tbl[27] = v(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);

        reset = 1'b1; sel_i = 1'b1; ack_i = 1'b0; host_data_i = 8'h00;
        dat_valid_i = 1'b0; dat_i = 8'h00; status_valid_i = 1'b0; status_i = 8'h00;
        repeat (3) step();

        // Cycle table: reset, 6-byte command, 3 data bytes, status, message.
        for (int i = 0; i < 28; i++) begin
            reset = tbl[i].rst; sel_i = tbl[i].sel; ack_i = tbl[i].ack;
            host_data_i = tbl[i].hd; dat_valid_i = tbl[i].dv; dat_i = tbl[i].dat;
            status_valid_i = tbl[i].sv; status_i = tbl[i].st;
            #1;
            check($sformatf("vec%0d", i),
                  80'({cd_status_o, phase_o, bus_data_o, cmd_valid_o, dat_ready_o}),
                  80'({tbl[i].e_cd, tbl[i].e_ph, tbl[i].e_bd, tbl[i].e_cv, tbl[i].e_dr}));
            step();
        end
        check("cmd6_len", 80'(cmd_len_o), 80'(4'd6));
        check("cmd6_bytes_held", cmd_bytes_o, 80'h050403020108);
        check("cmd6_one_pulse", 80'(cv_cnt), 80'(1));
        check("data3_ready_pulses", 80'(dr_cnt), 80'(3));

        // 10-byte command: length only after the tenth byte.
        sel_i = 1'b1;
        step();
        sel_i = 1'b0;
        cv0 = cv_cnt;
        send_cmd(cmd10, 10);
        check("cmd10_one_pulse", 80'(cv_cnt - cv0), 80'(1));
        check("cmd10_len", 80'(cmd_len_o), 80'(4'd10));
        check("cmd10_bytes", cmd_bytes_o, 80'h09080706050403020128);
        check("cmd10_exec", 80'({cd_status_o, phase_o}), 80'(16'h9001));

        // ACK held high: REQ stays low and only one byte is consumed.
        dr0 = dr_cnt;
        dat_valid_i = 1'b1; dat_i = 8'h5A;
        #1;
        check("hold_take_first", 80'(dat_ready_o), 80'(1'b1));
        step();
        check("hold_first_req", 80'({cd_status_o, bus_data_o}), 80'(16'hC85A));
        dat_i = 8'h6B; ack_i = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_req_low%0d", k), 80'({cd_status_o, dat_ready_o}), 80'({8'h88, 1'b0}));
            step();
        end
        check("hold_one_byte", 80'(dr_cnt - dr0), 80'(1));
        ack_i = 1'b0;
        #1;
        check("hold_release_take", 80'(dat_ready_o), 80'(1'b1));
        step();
        check("hold_req_back", 80'({cd_status_o, bus_data_o}), 80'(16'hC86B));
        check("hold_two_bytes", 80'(dr_cnt - dr0), 80'(2));
        dat_valid_i = 1'b0; ack_i = 1'b1;
        step();
        ack_i = 1'b0; status_valid_i = 1'b1; status_i = 8'h02;
        step();
        status_valid_i = 1'b0;
        check("status_entry", 80'({cd_status_o, phase_o, bus_data_o}), 80'(24'hD80802));

        // No ACK in STATUS.
        to0 = to_cnt;
`ifdef SCSI_PHASE_TIMEOUT_EN
        ok = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (cd_status_o !== 8'hD8 || timeout_o !== 1'b0) ok = 1'b0;
        end
        check("tmo_hold_15", 80'(ok), 80'(1'b1));
        step();
        check("tmo_abort", 80'({cd_status_o, phase_o, bus_data_o, cmd_len_o, timeout_o}),
              80'({8'h00, 8'h00, 8'h00, 4'd0, 1'b1}));
        check("tmo_keeps_cmd", cmd_bytes_o, 80'h09080706050403020128);
        step();
        check("tmo_one_pulse", 80'({to_cnt - to0, 31'd0, timeout_o}), 80'({32'd1, 31'd0, 1'b0}));
`else
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (cd_status_o !== 8'hD8 || timeout_o !== 1'b0) ok = 1'b0;
        end
        check("req_held_no_timeout", 80'(ok), 80'(1'b1));
        check("no_timeout_pulse", 80'(to_cnt - to0), 80'(0));
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        check("msg_in_req", 80'({cd_status_o, phase_o, bus_data_o}), 80'(24'hF81000));
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        check("back_to_free", 80'({cd_status_o, phase_o}), 80'(16'h0000));
`endif

        // Reset in the middle of DATA_IN.
        sel_i = 1'b1;
        step();
        sel_i = 1'b0;
        send_cmd(cmd6, 6);
        check("inq_len", 80'(cmd_len_o), 80'(4'd6));
        dat_valid_i = 1'b1; dat_i = 8'hC3;
        step();
        check("rst_datain_entry", 80'({cd_status_o, bus_data_o}), 80'(16'hC8C3));
        dat_i = 8'hC4; ack_i = 1'b1;
        step();
        ack_i = 1'b0; reset = 1'b1;
        #1;
        check("rst_no_ready", 80'(dat_ready_o), 80'(1'b0));
        dr0 = dr_cnt;
        step();
        check("rst_abort", 80'({cd_status_o, phase_o, bus_data_o, cmd_len_o, cmd_valid_o}),
              80'({8'h00, 8'h00, 8'h00, 4'd0, 1'b0}));
        check("rst_cmd_clear", cmd_bytes_o, 80'h0);
        check("rst_no_pulse", 80'(dr_cnt - dr0), 80'(0));
        reset = 1'b0; dat_valid_i = 1'b0;
        step();
        check("rst_idle", 80'({cd_status_o, phase_o}), 80'(16'h0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
